// File: rtl/cdm16_b330_core.sv
// ----------------------------------------------------------------------------
// cdm16_b330_core
//   Two-stage pipelined 16x16 unsigned carry-disregard approximate multiplier.
//   Product columns 0..K-1 are the OR of their partial-product bits, with no
//   carries generated or passed upward. Columns K..31 are the exact sum of all
//   partial products whose weight is 2^K or higher.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous active-high reset
//   in_valid  in   1   A/B are captured on this edge
//   A         in  16   unsigned multiplicand
//   B         in  16   unsigned multiplier
//   out_valid out  1   R holds the result of a captured pair (2 edges later)
//   R         out 32   approximate unsigned product (held across bubbles)
// ----------------------------------------------------------------------------
module cdm16_b330_core #(
    parameter int unsigned K = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    output logic [31:0] R
);

    // Bits at or above column K belong to the exact region.
    localparam logic [31:0] HI_MASK = 32'hFFFF_FFFF << K;

    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        v1_q;

    logic [31:0] r_q;
    logic [31:0] r_d;
    logic        ov_q;

    logic [31:0] hi_sum;
    logic [31:0] lo_cols;

    // Stage 1: operand capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
        end else begin
            a_q  <= A;
            b_q  <= B;
            v1_q <= in_valid;
        end
    end

    // Exact region: each row is B shifted by i, with its sub-K bits cleared so
    // the row contributes only pp(i,j) with i+j >= K. Those bits can never
    // carry downward, so the sum is exactly zero below column K.
    // Approximate region: per-column OR of the partial-product bits.
    always_comb begin
        hi_sum  = '0;
        lo_cols = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (a_q[i]) begin
                hi_sum = hi_sum + ((({16'h0000, b_q}) << i) & HI_MASK);
            end
            for (int unsigned j = 0; j < 16; j++) begin
                if ((i + j) < K) begin
                    lo_cols[i + j] = lo_cols[i + j] | (a_q[i] & b_q[j]);
                end
            end
        end
        r_d = (hi_sum & HI_MASK) | (lo_cols & ~HI_MASK);
    end

    // Stage 2: result register; R is held during bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q  <= '0;
            ov_q <= 1'b0;
        end else begin
            ov_q <= v1_q;
            if (v1_q) begin
                r_q <= r_d;
            end
        end
    end

    assign R         = r_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_cdm16_b330_core.sv
module tb_cdm16_b330_core;

    localparam int unsigned K = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        out_valid;
    logic [31:0] R;

    int tests = 0;
    int fails = 0;

    // Cycle-level reference state.
    logic        m_p1v = 1'b0;
    logic [15:0] m_p1a = '0;
    logic [15:0] m_p1b = '0;
    logic        m_ov  = 1'b0;
    logic [31:0] m_r   = '0;
    logic [31:0] m_prod = '0;

    cdm16_b330_core #(.K(K)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .A(A),
        .B(B),
        .out_valid(out_valid),
        .R(R)
    );

    always #5 clk = ~clk;

    // Column rule computed bit by bit: low columns OR, high columns summed.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        longint unsigned hi;
        logic [31:0]     lo;
        hi = 0;
        lo = '0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                if (a[i] && b[j]) begin
                    if (i + j < int'(K)) lo[i + j] = 1'b1;
                    else hi = hi + (64'(1) << (i + j));
                end
            end
        end
        return 32'(hi) | lo;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_le(input string tag, input logic [31:0] obs, input logic [31:0] bound);
        tests++;
        assert (obs <= bound) else begin
            fails++;
            $error("FAIL %s observed=%h exceeds exact=%h", tag, obs, bound);
        end
    endtask

    // Drive one cycle, advance the reference, sample #1 after the edge.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b);
        in_valid = v;
        A = a;
        B = b;
        @(posedge clk);
        m_ov = m_p1v;
        if (m_p1v) begin
            m_r    = ref_mul(m_p1a, m_p1b);
            m_prod = 32'(m_p1a) * 32'(m_p1b);
        end
        m_p1v = v;
        m_p1a = a;
        m_p1b = b;
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("R", R, m_r);
        if (m_ov) chk_le("R_le_exact", R, m_prod);
    endtask

    task automatic model_reset();
        m_p1v = 1'b0;
        m_p1a = '0;
        m_p1b = '0;
        m_ov  = 1'b0;
        m_r   = '0;
    endtask

    logic [15:0] ra, rb;

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_R", R, 32'h0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reference model sanity on the listed cases.
        chk("ref_3x3", ref_mul(16'd3, 16'd3), 32'h7);
        chk("ref_full", ref_mul(16'hFFFF, 16'hFFFF), 32'hFFFDF9FF);

        // Latency: result exactly two edges after capture.
        cycle(1'b1, 16'd3, 16'd3);
        chk("lat_edge1_ov", {31'd0, out_valid}, 32'd0);
        cycle(1'b0, 16'h0, 16'h0);
        chk("lat_edge2_ov", {31'd0, out_valid}, 32'd1);
        chk("lat_edge2_R", R, 32'h7);
        cycle(1'b0, 16'h0, 16'h0);

        // Back-to-back stream with one bubble.
        cycle(1'b1, 16'd3, 16'd3);
        cycle(1'b1, 16'd1, 16'hFFFF);
        chk("stream0_R", R, 32'h7);
        cycle(1'b1, 16'hFFFF, 16'hFFFF);
        chk("stream1_R", R, 32'h0000FFFF);
        cycle(1'b0, 16'h1234, 16'h5678);
        chk("stream2_R", R, 32'hFFFDF9FF);
        chk("stream2_ov", {31'd0, out_valid}, 32'd1);
        cycle(1'b1, 16'h0100, 16'h0100);
        chk("bubble_ov", {31'd0, out_valid}, 32'd0);
        chk("bubble_held", R, 32'hFFFDF9FF);
        cycle(1'b1, 16'h0000, 16'hABCD);
        chk("pow2_R", R, 32'h00010000);
        chk("pow2_ov", {31'd0, out_valid}, 32'd1);
        cycle(1'b0, 16'h0, 16'h0);
        chk("zero_R", R, 32'h0);
        cycle(1'b0, 16'h0, 16'h0);
        chk("drain_ov", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream with in_valid high.
        cycle(1'b1, 16'h00FF, 16'h0F0F);
        cycle(1'b1, 16'hFFFF, 16'h7777);
        #2;
        rst = 1'b1;
        #1;
        chk("async_R", R, 32'h0);
        chk("async_ov", {31'd0, out_valid}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        cycle(1'b1, 16'd3, 16'd3);
        chk("post_rst_edge1_ov", {31'd0, out_valid}, 32'd0);
        cycle(1'b0, 16'h0, 16'h0);
        chk("post_rst_ov", {31'd0, out_valid}, 32'd1);
        chk("post_rst_R", R, 32'h7);

        // Randomized regression, biased toward corner operands.
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 7))
                0: ra = 16'hFFFF;
                1: ra = 16'h0;
                2: ra = 16'(1) << $urandom_range(0, 15);
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: rb = 16'hFFFF;
                1: rb = 16'h0;
                2: rb = 16'(1) << $urandom_range(0, 15);
                default: rb = 16'($urandom);
            endcase
            cycle($urandom_range(0, 3) != 0, ra, rb);
        end
        cycle(1'b0, 16'h0, 16'h0);
        cycle(1'b0, 16'h0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
